// File: rtl/ack_if_tx_if.sv
// Handshake bundle between the upstream stream, the transmit controller and the CDC source port.
interface ack_if_tx_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ack;

  // Controller side: consumes the stream, drives the CDC source port
  modport master (
    input  in_data,
    input  in_valid,
    input  tx_ack,
    output in_ready,
    output tx_data,
    output tx_valid
  );

  // Environment side: produces the stream, returns the ack
  modport slave (
    output in_data,
    output in_valid,
    output tx_ack,
    input  in_ready,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/ack_if_tx.sv
// Source-side transmit controller for the acknowledged CDC synchronizer:
// one valid pulse per word, wait for ack, timeout/retry/drop, then a guard gap.
module ack_if_tx #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned MAX_RETRIES = 2,
  parameter int unsigned GUARD       = 4
) (
  input  logic         clk,
  input  logic         rst,
  ack_if_tx_if.master  bus,
  output logic         busy,
  output logic         timeout_pulse,
  output logic         drop_pulse
);

  localparam int unsigned TW         = $clog2(TIMEOUT + 1);
  localparam int unsigned RW         = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int unsigned GW         = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam int unsigned GUARD_LAST = (GUARD > 0) ? GUARD - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GUARD
  } state_t;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [RW-1:0]         retries;
  logic [GW-1:0]         guard_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tx_valid_q;
  logic                  timeout_q;
  logic                  drop_q;

  // Controller FSM with registered pulse outputs aligned to the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      retries    <= '0;
      guard_cnt  <= '0;
      data_q     <= '0;
      tx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            retries    <= '0;
            tx_valid_q <= 1'b1;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (bus.tx_ack) begin
            // ack takes priority over an expiring timer
            guard_cnt <= '0;
            state     <= (GUARD == 0) ? S_IDLE : S_GUARD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            if (retries < RW'(MAX_RETRIES)) begin
              retries    <= retries + RW'(1);
              timeout_q  <= 1'b1;
              tx_valid_q <= 1'b1;
              state      <= S_SEND;
            end else begin
              drop_q    <= 1'b1;
              guard_cnt <= '0;
              state     <= (GUARD == 0) ? S_IDLE : S_GUARD;
            end
          end
        end
        S_GUARD: begin
          // spacing gap so the pulse synchronizers never see pulses too close
          if (guard_cnt == GW'(GUARD_LAST)) begin
            state <= S_IDLE;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and upstream ready decoded from state
  always_comb begin
    busy         = (state != S_IDLE);
    bus.in_ready = (state == S_IDLE) && !rst;
  end

  // Registered outputs onto the bus and status ports
  always_comb begin
    bus.tx_data   = data_q;
    bus.tx_valid  = tx_valid_q;
    timeout_pulse = timeout_q;
    drop_pulse    = drop_q;
  end

endmodule

// File: tb/tb_ack_if_tx.sv
// Testbench for ack_if_tx: directed scenarios plus randomized traffic, all
// checked every cycle against a time-window model of the transmit protocol.
module tb_ack_if_tx;

  localparam int unsigned DW  = 4;
  localparam int unsigned TO  = 64;
  localparam int unsigned MR  = 2;
  localparam int unsigned GD  = 4;
  localparam int          BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic timeout_pulse;
  logic drop_pulse;

  ack_if_tx_if #(.DATA_WIDTH(DW)) bus();

  ack_if_tx #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO),
    .MAX_RETRIES(MR),
    .GUARD      (GD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Model: a word in flight is described by absolute cycle numbers of its
  // next send pulse, its ack window and the cycle it frees the block.
  int mc      = 0;
  int free_at = 0;
  int send_at = -1;
  int to_at   = -1;
  int drop_at = -1;
  int wlo     = -1;
  int whi     = -1;
  int attempt = 0;
  int word    = 0;
  int last_tv = -1;

  // Compare DUT against model mid-cycle, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    int eb;
    eb = (mc < free_at) ? 1 : 0;
    chk("busy",          int'(busy),             eb);
    chk("in_ready",      int'(bus.in_ready),     (eb == 0 && rst == 1'b0) ? 1 : 0);
    chk("tx_valid",      int'(bus.tx_valid),     (send_at == mc) ? 1 : 0);
    chk("tx_data",       int'(bus.tx_data),      word);
    chk("timeout_pulse", int'(timeout_pulse),    (to_at == mc) ? 1 : 0);
    chk("drop_pulse",    int'(drop_pulse),       (drop_at == mc) ? 1 : 0);
    if (bus.tx_valid === 1'b1) begin
      if (last_tv >= 0) chk("tv_spacing", (mc - last_tv >= 7) ? 1 : 0, 1);
      last_tv = mc;
    end

    if (rst) begin
      free_at = mc + 1;
      send_at = -1; to_at = -1; drop_at = -1;
      wlo = -1; whi = -1; word = 0; last_tv = -1;
    end else if (mc >= free_at && bus.in_valid) begin
      word    = int'(bus.in_data);
      attempt = 0;
      send_at = mc + 1;
      wlo     = mc + 2;
      whi     = mc + 1 + int'(TO);
      free_at = BIG;
    end else if (mc >= wlo && mc <= whi) begin
      if (bus.tx_ack) begin
        free_at = mc + 1 + int'(GD);
        wlo = -1; whi = -1;
      end else if (mc == whi) begin
        if (attempt < int'(MR)) begin
          attempt++;
          to_at   = mc + 1;
          send_at = mc + 1;
          wlo     = mc + 2;
          whi     = mc + 1 + int'(TO);
        end else begin
          drop_at = mc + 1;
          free_at = mc + 1 + int'(GD);
          wlo = -1; whi = -1;
        end
      end
    end
    mc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return in the cycle it is being sent
  task automatic send_word(input int d);
    int n;
    n = 0;
    bus.in_data  = DW'(d);
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("ready_wait", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Run until the block returns to IDLE
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    chk("idle_wait", int'(busy), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tv, to, dr, ack_cnt;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.tx_ack   = 1'b0;
    rst          = 1'b1;

    // 1: reset then a single word acked in its third WAIT cycle
    repeat (3) begin
      step();
      chk("t1_ready_in_rst", int'(bus.in_ready), 0);
    end
    rst = 1'b0;
    step();
    send_word(4'hA);
    chk("t1_tx_valid", int'(bus.tx_valid), 1);
    chk("t1_tx_data",  int'(bus.tx_data),  4'hA);
    step();
    chk("t1_tx_valid_off", int'(bus.tx_valid), 0);
    step();
    step();
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    chk("t1_busy_guard", int'(busy), 1);
    repeat (3) step();
    chk("t1_ready_guard", int'(bus.in_ready), 0);
    step();
    chk("t1_ready_back", int'(bus.in_ready), 1);
    chk("t1_busy_back",  int'(busy), 0);

    // 2: back-to-back stream with in_valid held high, ack two cycles after each pulse
    for (int w = 1; w <= 3; w++) begin
      send_word(w);
      bus.in_valid = (w < 3) ? 1'b1 : 1'b0;
      bus.in_data  = DW'(w + 1);
      chk("t2_tx_valid", int'(bus.tx_valid), 1);
      chk("t2_tx_data",  int'(bus.tx_data),  w);
      step();
      step();
      bus.tx_ack = 1'b1;
      chk("t2_ready_low", int'(bus.in_ready), 0);
      step();
      bus.tx_ack = 1'b0;
    end
    bus.in_valid = 1'b0;
    wait_idle();

    // 3: one timeout, then ack three cycles into the retry's WAIT
    send_word(4'h5);
    step();
    n = 0;
    while (timeout_pulse !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("t3_timeout_dist", n, 64);
    chk("t3_resend",       int'(bus.tx_valid), 1);
    chk("t3_resend_data",  int'(bus.tx_data),  4'h5);
    repeat (3) step();
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    dr = 0;
    repeat (6) begin
      dr += int'(drop_pulse);
      step();
    end
    chk("t3_no_drop", dr, 0);
    chk("t3_idle", int'(busy), 0);

    // 4: never acked, dropped after the third attempt
    send_word(4'h9);
    tv = 1; to = 0; n = 0;
    while (drop_pulse !== 1'b1 && n < 400) begin
      step();
      tv += int'(bus.tx_valid);
      to += int'(timeout_pulse);
      n++;
    end
    chk("t4_drop_seen", int'(drop_pulse), 1);
    chk("t4_tx_pulses", tv, 3);
    chk("t4_timeouts",  to, 2);
    repeat (3) step();
    chk("t4_guard_busy", int'(busy), 1);
    step();
    chk("t4_idle", int'(busy), 0);

    // 5: ack on the very cycle the timer expires
    send_word(4'h6);
    step();
    repeat (63) step();
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    chk("t5_no_timeout", int'(timeout_pulse), 0);
    chk("t5_no_drop",    int'(drop_pulse),    0);
    chk("t5_no_resend",  int'(bus.tx_valid),  0);
    chk("t5_guard",      int'(busy),          1);
    wait_idle();

    // 6: reset during WAIT, then a stray ack in IDLE
    send_word(4'h7);
    step();
    step();
    rst = 1'b1;
    step();
    chk("t6_busy",     int'(busy),          0);
    chk("t6_tx_valid", int'(bus.tx_valid),  0);
    chk("t6_drop",     int'(drop_pulse),    0);
    chk("t6_ready",    int'(bus.in_ready),  0);
    rst = 1'b0;
    step();
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    chk("t6_stray_busy",  int'(busy),         0);
    chk("t6_stray_valid", int'(bus.tx_valid), 0);
    chk("t6_stray_ready", int'(bus.in_ready), 1);

    // Randomized traffic: short, near-expiry and missing acks, stray acks, occasional reset
    ack_cnt = -1;
    for (int i = 0; i < 3000; i++) begin
      step();
      rst          = ($urandom_range(0, 299) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data  = DW'($urandom);
      bus.tx_ack   = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) bus.tx_ack = 1'b1;
      end
      if (bus.tx_valid === 1'b1) begin
        n = $urandom_range(0, 9);
        if (n < 6)      ack_cnt = $urandom_range(1, 6);
        else if (n < 8) ack_cnt = $urandom_range(60, 66);
        else            ack_cnt = -1;
      end
      if ($urandom_range(0, 29) == 0) bus.tx_ack = 1'b1;
    end

    bus.in_valid = 1'b0;
    bus.tx_ack   = 1'b0;
    rst          = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
